// File: rtl/frogger_pkg.sv
// Shared definitions for the frog player controller.
// Contents: player FSM state encoding, score values for a filled pad and for
// completing a level, and the bit index of each direction in move vectors.
package frogger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ALIVE     = 2'd1,
    ST_DYING     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  localparam int PAD_SCORE   = 10;  // points for landing on an empty pad
  localparam int LEVEL_BONUS = 50;  // extra points when the last pad fills

  // Bit positions in the 4-bit button / move vectors (also the priority order).
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;
  localparam int NUM_DIRS  = 4;

endpackage

// File: rtl/frog_move_gen.sv
// Button edge detector and optional auto-repeat generator.
// Optional feature: FROG_MOVE_REPEAT_EN enables auto-repeat of a held direction.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   frame_tick   - one-cycle pulse per video frame (repeat timebase)
//   enable       - frog is alive; repeat timing only runs while set
//   btn[3:0]     - debounced buttons, indexed by DIR_* from frogger_pkg
//   move[3:0]    - one-cycle move pulses, same indexing
module frog_move_gen
  import frogger_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic                enable,
  input  logic [NUM_DIRS-1:0] btn,
  output logic [NUM_DIRS-1:0] move
);

  logic [NUM_DIRS-1:0] btn_reg;
  logic [NUM_DIRS-1:0] edge_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_reg <= '0;
    end else begin
      btn_reg <= btn;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIRS; gi++) begin : g_edge
      assign edge_pulse[gi] = btn[gi] & ~btn_reg[gi];
    end
  endgenerate

`ifdef FROG_MOVE_REPEAT_EN
  // The held direction is the highest-priority pressed button, one-hot.
  logic [NUM_DIRS-1:0] held;
  logic [NUM_DIRS-1:0] held_reg;
  logic [2:0]          rpt_cnt_reg;
  logic                rpt_fire;

  always_comb begin
    held = '0;
    if (btn[DIR_UP])         held[DIR_UP]    = 1'b1;
    else if (btn[DIR_DOWN])  held[DIR_DOWN]  = 1'b1;
    else if (btn[DIR_LEFT])  held[DIR_LEFT]  = 1'b1;
    else if (btn[DIR_RIGHT]) held[DIR_RIGHT] = 1'b1;
  end

  // Counter restarts whenever the held direction changes or is released;
  // the 3-bit counter wraps so it fires on every 8th tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_reg    <= '0;
      rpt_cnt_reg <= '0;
    end else begin
      held_reg <= held;
      if (!enable || (held == '0) || (held != held_reg)) begin
        rpt_cnt_reg <= '0;
      end else if (frame_tick) begin
        rpt_cnt_reg <= rpt_cnt_reg + 3'd1;
      end
    end
  end

  assign rpt_fire = enable && (held != '0) && (held == held_reg) &&
                    frame_tick && (rpt_cnt_reg == 3'd7);
  assign move     = edge_pulse | (rpt_fire ? held : '0);
`else
  logic unused_inputs;
  assign unused_inputs = enable ^ frame_tick;
  assign move          = edge_pulse;
`endif

endmodule

// File: rtl/frog_player_ctrl.sv
// Frog player controller: position, lives, score, goal pads and death timing.
// Optional feature: FROG_MOVE_REPEAT_EN (auto-repeat of held directions,
// implemented inside frog_move_gen).
// Ports:
//   i_Clk, i_Rst_L          - clock, asynchronous active-low reset
//   i_Frame_Tick            - one pulse per video frame
//   i_Up/Down/Left/Right_Mvt- debounced buttons
//   i_Game_Active           - game running; low forces IDLE
//   i_Collided              - hazard overlap this cycle
//   i_Col/Row_Count_Div     - current tile coordinates of the video scan
//   o_Draw_Frogger          - registered frog pixel enable
//   o_Frogger_X/Y           - frog tile position
//   o_Score, o_Lives, o_Pads_Filled, o_Game_Over, o_State - status
module frog_player_ctrl
  import frogger_pkg::*;
#(
  parameter int GRID_W      = 14,
  parameter int GRID_H      = 15,
  parameter int START_X     = 10,
  parameter int START_Y     = 14,
  parameter int LIVES       = 3,
  parameter int PAD_COUNT   = 5,
  parameter int PAD_OFFSET  = 1,
  parameter int PAD_SPACING = 3,
  parameter int DEATH_TICKS = 30,
  parameter int SCORE_W     = 7
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Frame_Tick,
  input  logic                 i_Up_Mvt,
  input  logic                 i_Down_Mvt,
  input  logic                 i_Left_Mvt,
  input  logic                 i_Right_Mvt,
  input  logic                 i_Game_Active,
  input  logic                 i_Collided,
  input  logic [5:0]           i_Col_Count_Div,
  input  logic [5:0]           i_Row_Count_Div,
  output logic                 o_Draw_Frogger,
  output logic [5:0]           o_Frogger_X,
  output logic [5:0]           o_Frogger_Y,
  output logic [SCORE_W-1:0]   o_Score,
  output logic [2:0]           o_Lives,
  output logic [PAD_COUNT-1:0] o_Pads_Filled,
  output logic                 o_Game_Over,
  output logic [1:0]           o_State
);

  // Death counter needs at least 3 bits because bit 2 drives the blink.
  localparam int DC_W  = ($clog2(DEATH_TICKS + 1) < 3) ? 3 : $clog2(DEATH_TICKS + 1);
  localparam int SUM_W = SCORE_W + 7;

  state_t               state_reg, state_next;
  logic [5:0]           x_reg, y_reg, x_move, y_move;
  logic [SCORE_W-1:0]   score_reg, score_goal;
  logic [2:0]           lives_reg;
  logic [PAD_COUNT-1:0] pads_reg, pad_hit, pads_merged;
  logic [DC_W-1:0]      death_cnt_reg;
  logic                 draw_reg;
  logic                 alive, game_over;
  logic                 goal_eval, goal_ok, level_done, dies, death_done;
  logic [6:0]           score_add;
  logic [SUM_W-1:0]     score_sum;
  logic [NUM_DIRS-1:0]  move;

  frog_move_gen u_move_gen (
    .clk        (i_Clk),
    .rst_n      (i_Rst_L),
    .frame_tick (i_Frame_Tick),
    .enable     (alive),
    .btn        ({i_Right_Mvt, i_Left_Mvt, i_Down_Mvt, i_Up_Mvt}),
    .move       (move)
  );

  // Highest-priority pulse wins even when it is blocked by an edge.
  always_comb begin
    x_move = x_reg;
    y_move = y_reg;
    if (move[DIR_UP]) begin
      if (y_reg != 6'd0) y_move = y_reg - 6'd1;
    end else if (move[DIR_DOWN]) begin
      if (y_reg != 6'(GRID_H - 1)) y_move = y_reg + 6'd1;
    end else if (move[DIR_LEFT]) begin
      if (x_reg != 6'd0) x_move = x_reg - 6'd1;
    end else if (move[DIR_RIGHT]) begin
      if (x_reg != 6'(GRID_W - 1)) x_move = x_reg + 6'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PAD_COUNT; gi++) begin : g_pad
      assign pad_hit[gi] = (x_reg == 6'(PAD_OFFSET + gi * PAD_SPACING));
    end
  endgenerate

  // Goal evaluation happens on the cycle after the frog reaches row 0;
  // a collision in that cycle takes precedence.
  assign goal_eval   = alive && (y_reg == 6'd0) && !i_Collided;
  assign goal_ok     = |(pad_hit & ~pads_reg);
  assign pads_merged = pads_reg | pad_hit;
  assign level_done  = &pads_merged;
  assign dies        = alive && (i_Collided || (goal_eval && !goal_ok));
  assign death_done  = i_Frame_Tick && (death_cnt_reg == DC_W'(DEATH_TICKS - 1));

  assign score_add  = level_done ? 7'(PAD_SCORE + LEVEL_BONUS) : 7'(PAD_SCORE);
  assign score_sum  = SUM_W'(score_reg) + SUM_W'(score_add);
  assign score_goal = (|score_sum[SUM_W-1:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (i_Game_Active) state_next = ST_ALIVE;
      ST_ALIVE:     if (dies) state_next = ST_DYING;
      ST_DYING:     if (death_done) state_next = (lives_reg != 3'd0) ? ST_ALIVE : ST_GAME_OVER;
      ST_GAME_OVER: state_next = ST_GAME_OVER;
      default:      state_next = ST_IDLE;
    endcase
    if (!i_Game_Active) state_next = ST_IDLE;
  end

  // Output decode
  always_comb begin
    alive     = (state_reg == ST_ALIVE);
    game_over = (state_reg == ST_GAME_OVER);
  end

  // Datapath: everything freezes while the game is inactive.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      x_reg         <= 6'(START_X);
      y_reg         <= 6'(START_Y);
      score_reg     <= '0;
      lives_reg     <= 3'(LIVES);
      pads_reg      <= '0;
      death_cnt_reg <= '0;
    end else if (i_Game_Active) begin
      case (state_reg)
        ST_IDLE: begin
          x_reg         <= 6'(START_X);
          y_reg         <= 6'(START_Y);
          score_reg     <= '0;
          lives_reg     <= 3'(LIVES);
          pads_reg      <= '0;
          death_cnt_reg <= '0;
        end
        ST_ALIVE: begin
          if (dies) begin
            lives_reg     <= lives_reg - 3'd1;
            death_cnt_reg <= '0;
          end else if (goal_eval) begin
            score_reg <= score_goal;
            pads_reg  <= level_done ? '0 : pads_merged;
            x_reg     <= 6'(START_X);
            y_reg     <= 6'(START_Y);
          end else begin
            x_reg <= x_move;
            y_reg <= y_move;
          end
        end
        ST_DYING: begin
          if (death_done) begin
            death_cnt_reg <= '0;
            x_reg         <= 6'(START_X);
            y_reg         <= 6'(START_Y);
          end else if (i_Frame_Tick) begin
            death_cnt_reg <= death_cnt_reg + DC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel enable, one cycle behind the tile counters; blinks while dying.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      draw_reg <= 1'b0;
    end else begin
      draw_reg <= (i_Col_Count_Div == x_reg) && (i_Row_Count_Div == y_reg) &&
                  (alive || ((state_reg == ST_DYING) && death_cnt_reg[2]));
    end
  end

  assign o_Draw_Frogger = draw_reg;
  assign o_Frogger_X    = x_reg;
  assign o_Frogger_Y    = y_reg;
  assign o_Score        = score_reg;
  assign o_Lives        = lives_reg;
  assign o_Pads_Filled  = pads_reg;
  assign o_Game_Over    = game_over;
  assign o_State        = state_reg;

endmodule
